// File: rtl/spu_pkg.sv
// Shared SPU definitions: SP result-pipe geometry and the in-flight packet format.
package spu_pkg;

  localparam int unsigned SP_LATENCY     = 6;
  localparam int unsigned SP_FLUSH_DEPTH = 3;
  localparam int unsigned REG_ADDR_W     = 7;
  localparam int unsigned SP_DATA_W      = 128;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [0:REG_ADDR_W-1] rt_addr;
    logic [0:SP_DATA_W-1]  result;
  } sp_pkt_t;

endpackage

// File: rtl/sp_result_pipe_if.sv
// Issue-side inputs, forwarding taps and write-back port of the SP result pipe.
interface sp_result_pipe_if
  import spu_pkg::*;
#(
  parameter int unsigned LATENCY = SP_LATENCY,
  parameter int unsigned DATA_W  = SP_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W
);

  logic                         in_valid;
  logic [0:DATA_W-1]            in_result;
  logic [0:ADDR_W-1]            in_rt_addr;
  logic                         in_reg_write;
  logic                         flush;

  logic [LATENCY-1:0]           fwd_valid;
  logic [LATENCY*ADDR_W-1:0]    fwd_rt_addr;
  logic [LATENCY*DATA_W-1:0]    fwd_result;

  logic                         wb_valid;
  logic [0:ADDR_W-1]            wb_rt_addr;
  logic [0:DATA_W-1]            wb_result;

  logic [$clog2(LATENCY+1)-1:0] occupancy;

  modport master (
    output in_valid, in_result, in_rt_addr, in_reg_write, flush,
    input  fwd_valid, fwd_rt_addr, fwd_result,
    input  wb_valid, wb_rt_addr, wb_result, occupancy
  );

  modport slave (
    input  in_valid, in_result, in_rt_addr, in_reg_write, flush,
    output fwd_valid, fwd_rt_addr, fwd_result,
    output wb_valid, wb_rt_addr, wb_result, occupancy
  );

endinterface

// File: rtl/sp_pipe_stage.sv
// One SP result-pipe stage: a packet register with synchronous reset and a valid-only kill.
module sp_pipe_stage
  import spu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    kill,
  input  sp_pkt_t pkt_in,
  output sp_pkt_t pkt_out
);

  sp_pkt_t pkt_d;
  sp_pkt_t pkt_q;

  // Kill drops only the valid bit; payload still shifts so forwarders must qualify.
  always_comb begin
    pkt_d       = pkt_in;
    pkt_d.valid = pkt_in.valid & ~kill;
  end

  always_ff @(posedge clk) begin
    if (reset) pkt_q <= '0;
    else       pkt_q <= pkt_d;
  end

  assign pkt_out = pkt_q;

endmodule

// File: rtl/sp_result_pipe.sv
// Fixed-latency result pipe behind the SP FP adder: forwarding taps, write-back, flush kill.
module sp_result_pipe
  import spu_pkg::*;
#(
  parameter int unsigned LATENCY     = SP_LATENCY,
  parameter int unsigned FLUSH_DEPTH = SP_FLUSH_DEPTH,
  parameter int unsigned DATA_W      = SP_DATA_W,
  parameter int unsigned ADDR_W      = REG_ADDR_W
) (
  input logic              clk,
  input logic              reset,
  sp_result_pipe_if.slave  bus
);

  localparam int unsigned OCC_W = $clog2(LATENCY + 1);

  sp_pkt_t            stage_in [LATENCY];
  sp_pkt_t            stage_q  [LATENCY];
  logic [LATENCY-1:0] kill;

  logic [OCC_W-1:0]          occ_d;
  logic [OCC_W-1:0]          occ_q;
  int unsigned               occ_cnt;

  logic [LATENCY-1:0]        fwd_valid_c;
  logic [LATENCY*ADDR_W-1:0] fwd_rt_addr_c;
  logic [LATENCY*DATA_W-1:0] fwd_result_c;

  always_comb begin
    stage_in[0].valid     = bus.in_valid;
    stage_in[0].reg_write = bus.in_reg_write;
    stage_in[0].rt_addr   = bus.in_rt_addr;
    stage_in[0].result    = bus.in_result;
    for (int unsigned s = 1; s < LATENCY; s++) begin
      stage_in[s] = stage_q[s-1];
    end
    for (int unsigned s = 0; s < LATENCY; s++) begin
      kill[s] = bus.flush && (s < FLUSH_DEPTH);
    end
  end

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    sp_pipe_stage u_stage (
      .clk     (clk),
      .reset   (reset),
      .kill    (kill[g]),
      .pkt_in  (stage_in[g]),
      .pkt_out (stage_q[g])
    );
  end

  // Incremental count: never negative, since retire + kills only remove packets already counted.
  always_comb begin
    occ_cnt = 32'(occ_q);
    if (bus.in_valid && !kill[0])     occ_cnt = occ_cnt + 1;
    if (stage_q[LATENCY-1].valid)     occ_cnt = occ_cnt - 1;
    for (int unsigned s = 1; s < LATENCY; s++) begin
      if (kill[s] && stage_q[s-1].valid) occ_cnt = occ_cnt - 1;
    end
    occ_d = OCC_W'(occ_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  always_comb begin
    fwd_valid_c   = '0;
    fwd_rt_addr_c = '0;
    fwd_result_c  = '0;
    for (int unsigned s = 0; s < LATENCY; s++) begin
      fwd_valid_c[s]                     = stage_q[s].valid;
      fwd_rt_addr_c[s*ADDR_W +: ADDR_W]  = stage_q[s].rt_addr;
      fwd_result_c[s*DATA_W +: DATA_W]   = stage_q[s].result;
    end
  end

  assign bus.fwd_valid   = fwd_valid_c;
  assign bus.fwd_rt_addr = fwd_rt_addr_c;
  assign bus.fwd_result  = fwd_result_c;

  assign bus.wb_valid    = stage_q[LATENCY-1].valid & stage_q[LATENCY-1].reg_write;
  assign bus.wb_rt_addr  = stage_q[LATENCY-1].rt_addr;
  assign bus.wb_result   = stage_q[LATENCY-1].result;
  assign bus.occupancy   = occ_q;

endmodule
